msg_assembler: RTL and testbench
================================

MSG_ASSEMBLER -- requirements
Module: msg_assembler

Interface
- REQ-001: Parameter REG_WIDTH, default 32; width of each inbound word and each output register.
- REQ-002: Parameter NUM_REGS, default 9; number of words per message.
- REQ-003: i_clk  input  1  sole clock; all state changes on its rising edge.
- REQ-004: i_reset  input  1  synchronous, active-high reset.
- REQ-005: i_word_valid  input  1  inbound word present.
- REQ-006: i_word  input  REG_WIDTH  inbound message word; word k of a message maps to o_reg_k.
- REQ-007: i_word_last  input  1  marks the final word of a message.
- REQ-008: o_word_ready  output  1  word accepted on an edge where i_word_valid & o_word_ready.
- REQ-009: i_book_is_busy  input  1  order book cannot accept a message this cycle.
- REQ-010: o_reg_0 .. o_reg_8  output  REG_WIDTH each  assembled message registers, parser input format.
- REQ-011: o_data_valid  output  1  assembled message presented this cycle, one-cycle pulse per message.
- REQ-012: o_frame_error  output  1  registered one-cycle pulse per dropped message.
- REQ-013: o_msg_count  output  16  messages delivered; wraps at 2^16.
- REQ-014: o_err_count  output  16  messages dropped; saturates at 16'hFFFF.

Function
- REQ-015: FSM states are COLLECT, HOLD and DISCARD.
- REQ-016: Reset state is COLLECT.
- REQ-017: A 4-bit word index counts accepted words, 0..NUM_REGS-1.
- REQ-018: o_word_ready shall be 1 in COLLECT and DISCARD and 0 in HOLD.
- REQ-019: In COLLECT, an accepted word shall load o_reg_<index> and increment the index; other registers hold.
- REQ-020: Index 0 byte [7:0] not in {8'h41, 8'h44, 8'h45} shall be a type error.
- REQ-021: Type error with i_word_last = 1 -> stay in COLLECT; type error with i_word_last = 0 -> DISCARD.
- REQ-022: i_word_last = 1 at index < NUM_REGS-1 shall be a short-frame error; stay in COLLECT with index cleared.
- REQ-023: Index NUM_REGS-1 accepted with i_word_last = 0 shall be a long-frame error; go to DISCARD.
- REQ-024: Index NUM_REGS-1 accepted with i_word_last = 1 and a valid type -> HOLD, index cleared.
- REQ-025: Every error shall pulse o_frame_error on the following cycle and increment o_err_count (saturating).
- REQ-026: No error shall ever assert o_data_valid.
- REQ-027: DISCARD shall accept and drop words; an accepted word with i_word_last = 1 -> COLLECT, index 0.
- REQ-028: o_data_valid = (state == HOLD) & ~i_book_is_busy, combinational.
- REQ-029: On that same edge the FSM shall go to COLLECT and o_msg_count shall increment.
- REQ-030: Latency: last word accepted at edge N -> o_data_valid in the cycle after N at the earliest.
- REQ-031: While i_book_is_busy stays high, HOLD persists indefinitely with no timeout.
- REQ-032: o_reg_0..8 shall remain stable throughout HOLD and the o_data_valid cycle.
- REQ-033: No word is accepted in the o_data_valid cycle; back-to-back messages are separated by at least one non-accepting cycle.
- REQ-034: Reset asserted mid-message or in HOLD drops the partial or held message with no o_data_valid and no error count.

Reset
- REQ-035: On i_reset all of the following shall be 0: o_reg_0..8, index, o_data_valid, o_frame_error, o_msg_count, o_err_count.
- REQ-036: On i_reset state = COLLECT, so o_word_ready = 1 on the first cycle after reset.

Structure
- REQ-037: Shared package hft_pkg shall hold REG_WIDTH, NUM_REGS, the type codes MSG_ADD = 8'h41, MSG_DELETE = 8'h44 and MSG_EXECUTE = 8'h45, and the assembler state enum.
- REQ-038: Single module; no sub-module; the register file is an array indexed by word index.

Verification
- REQ-039: 9-word add message, word0 = 32'h00120041, busy = 0 -> o_data_valid one cycle after last word; o_reg_k = word k; o_msg_count = 1.
- REQ-040: Busy high for 5 cycles from completion -> o_word_ready = 0 for 5 cycles, registers stable, exactly one o_data_valid when busy falls.
- REQ-041: i_word_last at word 4 -> o_frame_error pulse, o_err_count = 1, no o_data_valid; following valid delete message delivered.
- REQ-042: word0 byte 8'h58, last at word 8 -> DISCARD; all words accepted; o_err_count = 1; next message delivered.
- REQ-043: 12 words with last only at word 11 -> error at word 8, words 9-11 discarded, back in COLLECT.
- REQ-044: Reset at word 5 -> no o_data_valid, counters 0; next full execute message delivered with o_msg_count = 1.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared definitions for the order-entry message path: word geometry,
// recognised message type codes and the assembler state encoding.
package hft_pkg;

  localparam int REG_WIDTH = 32;
  localparam int NUM_REGS  = 9;

  localparam logic [7:0] MSG_ADD     = 8'h41;
  localparam logic [7:0] MSG_DELETE  = 8'h44;
  localparam logic [7:0] MSG_EXECUTE = 8'h45;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_HOLD,
    ST_DISCARD
  } asm_state_t;

  function automatic logic is_valid_type(input logic [7:0] code);
    return (code == MSG_ADD) || (code == MSG_DELETE) || (code == MSG_EXECUTE);
  endfunction

endpackage

// File: rtl/msg_assembler.sv
// Collects a fixed-length stream of words into a register bank for the parser,
// holds the frame until the order book is free, and drops malformed frames.
module msg_assembler #(
  parameter int REG_WIDTH = hft_pkg::REG_WIDTH,
  parameter int NUM_REGS  = hft_pkg::NUM_REGS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_word_valid,
  input  logic [REG_WIDTH-1:0] i_word,
  input  logic                 i_word_last,
  output logic                 o_word_ready,
  input  logic                 i_book_is_busy,
  output logic [REG_WIDTH-1:0] o_reg_0,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic [REG_WIDTH-1:0] o_reg_8,
  output logic                 o_data_valid,
  output logic                 o_frame_error,
  output logic [15:0]          o_msg_count,
  output logic [15:0]          o_err_count
);

  import hft_pkg::*;

  // The output bank always exposes nine slots even if fewer words are used.
  localparam int         REG_SLOTS = (NUM_REGS > 9) ? NUM_REGS : 9;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);

  asm_state_t           state, state_next;
  logic [3:0]           idx, idx_next;
  logic [REG_WIDTH-1:0] regs [REG_SLOTS];
  logic                 accept, at_last, type_ok, err;

  assign o_word_ready = (state != ST_HOLD);
  assign accept       = i_word_valid & o_word_ready;
  assign o_data_valid = (state == ST_HOLD) & ~i_book_is_busy;
  assign at_last      = (idx == LAST_IDX);
  // Word 0 is judged live; later words rely on the already-captured word 0.
  assign type_ok      = is_valid_type((idx == 4'd0) ? i_word[7:0] : regs[0][7:0]);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    err        = 1'b0;
    unique case (state)
      ST_COLLECT: begin
        if (accept) begin
          if (!type_ok) begin
            err        = 1'b1;
            idx_next   = 4'd0;
            state_next = i_word_last ? ST_COLLECT : ST_DISCARD;
          end else if (at_last) begin
            idx_next   = 4'd0;
            state_next = i_word_last ? ST_HOLD : ST_DISCARD;
            err        = ~i_word_last;
          end else if (i_word_last) begin
            err      = 1'b1;
            idx_next = 4'd0;
          end else begin
            idx_next = idx + 4'd1;
          end
        end
      end
      ST_HOLD: begin
        if (!i_book_is_busy) state_next = ST_COLLECT;
      end
      ST_DISCARD: begin
        idx_next = 4'd0;
        if (accept && i_word_last) state_next = ST_COLLECT;
      end
      default: begin
        state_next = ST_COLLECT;
        idx_next   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_COLLECT;
      idx           <= 4'd0;
      o_frame_error <= 1'b0;
      o_msg_count   <= 16'd0;
      o_err_count   <= 16'd0;
      // NOTE: the register bank is cleared on reset because its contents are
      // visible outputs; it is small flops, not a RAM macro.
      for (int i = 0; i < REG_SLOTS; i++) regs[i] <= '0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      o_frame_error <= err;
      if (err && (o_err_count != 16'hFFFF)) o_err_count <= o_err_count + 16'd1;
      if (o_data_valid) o_msg_count <= o_msg_count + 16'd1;
      if ((state == ST_COLLECT) && accept) regs[idx] <= i_word;
    end
  end

  assign o_reg_0 = regs[0];
  assign o_reg_1 = regs[1];
  assign o_reg_2 = regs[2];
  assign o_reg_3 = regs[3];
  assign o_reg_4 = regs[4];
  assign o_reg_5 = regs[5];
  assign o_reg_6 = regs[6];
  assign o_reg_7 = regs[7];
  assign o_reg_8 = regs[8];

endmodule

// File: tb/tb_msg_assembler.sv
// Directed bench for msg_assembler: delivery, busy back-pressure, short, long
// and bad-type frames, and reset in mid-message.
module tb_msg_assembler;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_word_valid;
  logic [31:0] i_word;
  logic        i_word_last;
  logic        o_word_ready;
  logic        i_book_is_busy;
  logic [31:0] o_reg_0, o_reg_1, o_reg_2, o_reg_3, o_reg_4;
  logic [31:0] o_reg_5, o_reg_6, o_reg_7, o_reg_8;
  logic        o_data_valid;
  logic        o_frame_error;
  logic [15:0] o_msg_count;
  logic [15:0] o_err_count;

  logic [31:0] regs_obs [9];
  assign regs_obs[0] = o_reg_0;
  assign regs_obs[1] = o_reg_1;
  assign regs_obs[2] = o_reg_2;
  assign regs_obs[3] = o_reg_3;
  assign regs_obs[4] = o_reg_4;
  assign regs_obs[5] = o_reg_5;
  assign regs_obs[6] = o_reg_6;
  assign regs_obs[7] = o_reg_7;
  assign regs_obs[8] = o_reg_8;

  msg_assembler dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_word_valid   (i_word_valid),
    .i_word         (i_word),
    .i_word_last    (i_word_last),
    .o_word_ready   (o_word_ready),
    .i_book_is_busy (i_book_is_busy),
    .o_reg_0        (o_reg_0),
    .o_reg_1        (o_reg_1),
    .o_reg_2        (o_reg_2),
    .o_reg_3        (o_reg_3),
    .o_reg_4        (o_reg_4),
    .o_reg_5        (o_reg_5),
    .o_reg_6        (o_reg_6),
    .o_reg_7        (o_reg_7),
    .o_reg_8        (o_reg_8),
    .o_data_valid   (o_data_valid),
    .o_frame_error  (o_frame_error),
    .o_msg_count    (o_msg_count),
    .o_err_count    (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int dv_count = 0;
  int fe_count = 0;
  int acc_count = 0;

  // Inputs change just after rising edges, so the falling edge sees exactly
  // what the next rising edge will sample.
  always @(negedge i_clk) begin
    if (o_data_valid) dv_count++;
    if (o_frame_error) fe_count++;
    if (i_word_valid && o_word_ready) acc_count++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] typ, input logic [7:0] tag, input int k);
    if (k == 0) return {16'h0012, 8'h00, typ};
    return {tag, 16'h0000, 8'(k)};
  endfunction

  task automatic send_msg(input logic [7:0] typ, input logic [7:0] tag, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      int budget;
      i_word_valid = 1'b1;
      i_word       = exp_word(typ, tag, i);
      i_word_last  = (i == last_at);
      budget = 0;
      while (!o_word_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (!o_word_ready) check("word_ready_timeout", 32'(o_word_ready), 32'd1);
      tick();
    end
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
    i_word       = '0;
  endtask

  task automatic check_regs(input string tag, input logic [7:0] typ, input logic [7:0] wtag);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s_reg%0d", tag, k), regs_obs[k], exp_word(typ, wtag, k));
  endtask

  initial begin
    int dv0, fe0, acc0;
    i_reset        = 1'b1;
    i_word_valid   = 1'b0;
    i_word         = '0;
    i_word_last    = 1'b0;
    i_book_is_busy = 1'b0;
    repeat (3) tick();
    i_reset = 1'b0;

    check("rst_ready", 32'(o_word_ready), 32'd1);
    check("rst_dv", 32'(o_data_valid), 32'd0);
    check("rst_fe", 32'(o_frame_error), 32'd0);
    check("rst_msg_count", 32'(o_msg_count), 32'd0);
    check("rst_err_count", 32'(o_err_count), 32'd0);
    check("rst_reg0", o_reg_0, 32'd0);
    check("rst_reg8", o_reg_8, 32'd0);

    // Plain add message, book free: valid in the cycle right after the last word.
    dv0 = dv_count;
    send_msg(8'h41, 8'hA1, 9, 8);
    check("add_word0", o_reg_0, 32'h00120041);
    check("add_dv", 32'(o_data_valid), 32'd1);
    check("add_ready_low", 32'(o_word_ready), 32'd0);
    check_regs("add", 8'h41, 8'hA1);
    tick();
    check("add_dv_pulse", 32'(dv_count - dv0), 32'd1);
    check("add_msg_count", 32'(o_msg_count), 32'd1);
    check("add_ready_back", 32'(o_word_ready), 32'd1);

    // Busy for 5 cycles after completion.
    dv0 = dv_count;
    i_book_is_busy = 1'b1;
    send_msg(8'h44, 8'hB2, 9, 8);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("busy_ready_c%0d", c), 32'(o_word_ready), 32'd0);
      check($sformatf("busy_dv_c%0d", c), 32'(o_data_valid), 32'd0);
      check($sformatf("busy_reg0_c%0d", c), o_reg_0, exp_word(8'h44, 8'hB2, 0));
      check($sformatf("busy_reg8_c%0d", c), o_reg_8, exp_word(8'h44, 8'hB2, 8));
      tick();
    end
    i_book_is_busy = 1'b0;
    #1;
    check("busy_release_dv", 32'(o_data_valid), 32'd1);
    check_regs("busy", 8'h44, 8'hB2);
    tick();
    check("busy_dv_pulses", 32'(dv_count - dv0), 32'd1);
    check("busy_msg_count", 32'(o_msg_count), 32'd2);

    // Short frame: last at word 4.
    dv0 = dv_count; fe0 = fe_count;
    send_msg(8'h41, 8'hC3, 5, 4);
    check("short_fe", 32'(o_frame_error), 32'd1);
    check("short_err_count", 32'(o_err_count), 32'd1);
    check("short_ready", 32'(o_word_ready), 32'd1);
    tick();
    check("short_fe_pulse", 32'(fe_count - fe0), 32'd1);
    check("short_no_dv", 32'(dv_count - dv0), 32'd0);
    send_msg(8'h44, 8'hC4, 9, 8);
    check_regs("short_next", 8'h44, 8'hC4);
    tick();
    check("short_next_msg_count", 32'(o_msg_count), 32'd3);
    check("short_next_dv", 32'(dv_count - dv0), 32'd1);

    // Single bad-type word carrying last: error, stays collecting.
    fe0 = fe_count; dv0 = dv_count;
    send_msg(8'h99, 8'hD0, 1, 0);
    check("badlast_ready", 32'(o_word_ready), 32'd1);
    tick();
    check("badlast_err_count", 32'(o_err_count), 32'd2);
    check("badlast_fe_pulse", 32'(fe_count - fe0), 32'd1);

    // Bad type with last at word 8: whole frame discarded.
    fe0 = fe_count; dv0 = dv_count; acc0 = acc_count;
    send_msg(8'h58, 8'hD5, 9, 8);
    tick();
    check("disc_accepted", 32'(acc_count - acc0), 32'd9);
    check("disc_err_count", 32'(o_err_count), 32'd3);
    check("disc_fe_pulse", 32'(fe_count - fe0), 32'd1);
    check("disc_no_dv", 32'(dv_count - dv0), 32'd0);
    send_msg(8'h45, 8'hD6, 9, 8);
    check_regs("disc_next", 8'h45, 8'hD6);
    tick();
    check("disc_next_msg_count", 32'(o_msg_count), 32'd4);

    // Long frame: 12 words, last only on word 11.
    fe0 = fe_count; dv0 = dv_count; acc0 = acc_count;
    send_msg(8'h41, 8'hE7, 12, 11);
    tick();
    check("long_accepted", 32'(acc_count - acc0), 32'd12);
    check("long_err_count", 32'(o_err_count), 32'd4);
    check("long_fe_pulse", 32'(fe_count - fe0), 32'd1);
    check("long_no_dv", 32'(dv_count - dv0), 32'd0);
    check("long_ready", 32'(o_word_ready), 32'd1);
    send_msg(8'h41, 8'hE8, 9, 8);
    check("long_next_dv", 32'(o_data_valid), 32'd1);
    check_regs("long_next", 8'h41, 8'hE8);
    tick();
    check("long_next_msg_count", 32'(o_msg_count), 32'd5);

    // Reset after five words of a message.
    fe0 = fe_count; dv0 = dv_count;
    send_msg(8'h41, 8'hF9, 5, 99);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_msg_count", 32'(o_msg_count), 32'd0);
    check("mid_rst_err_count", 32'(o_err_count), 32'd0);
    check("mid_rst_reg0", o_reg_0, 32'd0);
    check("mid_rst_ready", 32'(o_word_ready), 32'd1);
    tick();
    check("mid_rst_no_dv", 32'(dv_count - dv0), 32'd0);
    check("mid_rst_no_fe", 32'(fe_count - fe0), 32'd0);
    send_msg(8'h45, 8'hFA, 9, 8);
    check("mid_rst_next_dv", 32'(o_data_valid), 32'd1);
    check_regs("mid_rst_next", 8'h45, 8'hFA);
    tick();
    check("mid_rst_next_msg_count", 32'(o_msg_count), 32'd1);
    check("mid_rst_next_err_count", 32'(o_err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
